// File: rtl/trace_fetch.sv
// Trace replay engine: walks a trace SRAM word by word and hands each entry
// to the cache model over a valid/ready handshake, one SRAM read per entry.
module trace_fetch #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   trace_len,
  output logic              csb0,
  output logic              web0,
  output logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] dout0,
  output logic [DATA_W-1:0] mem_addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   fetched_count
);

  typedef enum logic [1:0] {IDLE, READ, CAPT, SEND} state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   len_clip;
  logic [ADDR_W:0]   idx_inc;
  logic              handshake;
  logic              last;

  // Lengths beyond the memory depth are clipped so idx never wraps.
  assign len_clip  = (trace_len > MAX_LEN) ? MAX_LEN : trace_len;
  assign idx_inc   = {1'b0, idx} + ONE;
  assign handshake = (state == SEND) && addr_ready;
  assign last      = handshake && (idx_inc == len);

  assign csb0       = (state != READ);
  assign web0       = 1'b1;
  assign addr0      = idx;
  assign addr_valid = (state == SEND);
  assign busy       = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && (trace_len != '0)) state_next = READ;
      READ: state_next = CAPT;
      CAPT: state_next = SEND;
      SEND: if (handshake) state_next = last ? IDLE : READ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      idx           <= '0;
      len           <= '0;
      mem_addr      <= '0;
      done          <= 1'b0;
      fetched_count <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            fetched_count <= '0;
            if (trace_len == '0) begin
              done <= 1'b1;
            end else begin
              len <= len_clip;
              idx <= '0;
            end
          end
        end
        // SRAM data is valid the cycle after the read strobe.
        CAPT: mem_addr <= dout0;
        SEND: begin
          if (handshake) begin
            fetched_count <= fetched_count + ONE;
            if (last) done <= 1'b1;
            else      idx  <= idx_inc[ADDR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_fetch.sv
// Scoreboard bench for trace_fetch: stimulus pushes expected trace entries,
// a negedge monitor pops and compares them at every handshake.
module tb_trace_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [10:0] trace_len = '0;
  logic        csb0;
  logic        web0;
  logic [9:0]  addr0;
  logic [31:0] dout0 = '0;
  logic [31:0] mem_addr;
  logic        addr_valid;
  logic        addr_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [10:0] fetched_count;

  int checks = 0;
  int errors = 0;
  int read_cnt = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int last_read_addr = -1;
  logic [31:0] sb[$];
  logic        stall_pending = 1'b0;
  logic [31:0] stall_addr = '0;

  trace_fetch #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .trace_len(trace_len),
    .csb0(csb0), .web0(web0), .addr0(addr0), .dout0(dout0),
    .mem_addr(mem_addr), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .busy(busy), .done(done), .fetched_count(fetched_count)
  );

  always #5 clk = ~clk;

  // SRAM model: word i holds 0x1000+i, data appears one clock after the strobe
  always @(posedge clk) begin
    if (!csb0) dout0 <= 32'h1000 + {22'd0, addr0};
  end

  // Monitor: SRAM read accounting, done pulses, SEND stability and scoreboard pops
  always @(negedge clk) begin
    if (!csb0) begin
      read_cnt++;
      last_read_addr = int'(addr0);
      checks++;
      if (web0 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL web0_high: got %b expected 1", web0);
      end
    end
    if (done === 1'b1) done_cnt++;
    if (stall_pending) begin
      checks++;
      if (addr_valid !== 1'b1 || mem_addr !== stall_addr) begin
        errors++;
        $display("[TB] FAIL send_stable: got valid=%b addr=%h expected valid=1 addr=%h",
                 addr_valid, mem_addr, stall_addr);
      end
    end
    if (addr_valid === 1'b1 && addr_ready === 1'b1) begin
      hs_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_entry: got %h expected no entry", mem_addr);
      end else begin
        logic [31:0] exp_val;
        exp_val = sb.pop_front();
        if (mem_addr !== exp_val) begin
          errors++;
          $display("[TB] FAIL mem_addr: got %h expected %h", mem_addr, exp_val);
        end
      end
    end
    stall_pending = (addr_valid === 1'b1) && (addr_ready !== 1'b1);
    stall_addr    = mem_addr;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Pulse start for one cycle; returns #1 after the edge that sampled it
  task automatic applyStimulus(input logic [10:0] len);
    @(posedge clk); #1;
    start = 1'b1;
    trace_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pushEntries(input int first, input int count);
    for (int i = 0; i < count; i++) sb.push_back(32'h1000 + 32'(first + i));
  endtask

  task automatic waitDone(input int max_cycles);
    int c;
    c = 0;
    while (done !== 1'b1 && c < max_cycles) begin
      @(posedge clk); #1;
      c++;
    end
    checkOutput("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic waitValid(input int max_cycles);
    int c;
    c = 0;
    while (addr_valid !== 1'b1 && c < max_cycles) begin
      @(posedge clk); #1;
      c++;
    end
    checkOutput("valid_seen", {31'd0, addr_valid}, 32'd1);
  endtask

  initial begin
    int reads0, dones0, hs0, lat, sends;

    // Reset with start held high: start must be ignored while in reset
    reset = 1'b0;
    start = 1'b1;
    trace_len = 11'd4;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_csb0", {31'd0, csb0}, 32'd1);
    checkOutput("rst_web0", {31'd0, web0}, 32'd1);
    checkOutput("rst_addr0", {22'd0, addr0}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_valid", {31'd0, addr_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_count", {21'd0, fetched_count}, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("start_in_reset_ignored", {31'd0, busy}, 32'd0);

    // Basic replay of four entries, ready always high
    $display("[TB] replay trace_len=4");
    addr_ready = 1'b1;
    dones0 = done_cnt;
    reads0 = read_cnt;
    pushEntries(0, 4);
    applyStimulus(11'd4);
    checkOutput("busy_in_read", {31'd0, busy}, 32'd1);
    lat = 1;
    while (addr_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("first_valid_latency", 32'(lat), 32'd3);
    waitDone(30);
    checkOutput("busy_in_done", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("len4_count", {21'd0, fetched_count}, 32'd4);
    checkOutput("len4_done_pulses", 32'(done_cnt - dones0), 32'd1);
    checkOutput("len4_reads", 32'(read_cnt - reads0), 32'd4);
    checkOutput("len4_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure on entry 1: output must hold and no extra SRAM read may occur
    $display("[TB] replay trace_len=3 with stall");
    addr_ready = 1'b0;
    reads0 = read_cnt;
    pushEntries(0, 3);
    applyStimulus(11'd3);
    waitValid(10);
    addr_ready = 1'b1;
    @(posedge clk); #1;
    addr_ready = 1'b0;
    waitValid(10);
    hs0 = read_cnt;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stall_valid", {31'd0, addr_valid}, 32'd1);
    checkOutput("stall_mem_addr", mem_addr, 32'h1001);
    checkOutput("stall_no_read", 32'(read_cnt - hs0), 32'd0);
    addr_ready = 1'b1;
    waitDone(30);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("len3_count", {21'd0, fetched_count}, 32'd3);
    checkOutput("len3_reads", 32'(read_cnt - reads0), 32'd3);
    checkOutput("len3_sb_empty", 32'(sb.size()), 32'd0);

    // Zero-length replay: done next cycle, never busy, count cleared
    $display("[TB] replay trace_len=0");
    reads0 = read_cnt;
    dones0 = done_cnt;
    applyStimulus(11'd0);
    checkOutput("len0_done", {31'd0, done}, 32'd1);
    checkOutput("len0_busy", {31'd0, busy}, 32'd0);
    checkOutput("len0_count", {21'd0, fetched_count}, 32'd0);
    @(posedge clk); #1;
    checkOutput("len0_done_once", {31'd0, done}, 32'd0);
    checkOutput("len0_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("len0_no_read", 32'(read_cnt - reads0), 32'd0);
    checkOutput("len0_done_pulses", 32'(done_cnt - dones0), 32'd1);

    // Oversized length clips to full memory depth
    $display("[TB] replay trace_len=1100");
    hs0 = hs_cnt;
    dones0 = done_cnt;
    pushEntries(0, 1024);
    applyStimulus(11'd1100);
    waitDone(3200);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("clip_handshakes", 32'(hs_cnt - hs0), 32'd1024);
    checkOutput("clip_last_addr", 32'(last_read_addr), 32'd1023);
    checkOutput("clip_addr0_hold", {22'd0, addr0}, 32'd1023);
    checkOutput("clip_count", {21'd0, fetched_count}, 32'd1024);
    checkOutput("clip_done_pulses", 32'(done_cnt - dones0), 32'd1);
    checkOutput("clip_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during the second SEND aborts without done
    $display("[TB] reset during replay");
    dones0 = done_cnt;
    pushEntries(0, 2);
    applyStimulus(11'd4);
    sends = 0;
    for (int c = 0; c < 20 && sends < 2; c++) begin
      @(posedge clk); #1;
      if (addr_valid === 1'b1) sends++;
    end
    checkOutput("second_send_seen", 32'(sends), 32'd2);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_valid", {31'd0, addr_valid}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_csb0", {31'd0, csb0}, 32'd1);
    checkOutput("abort_addr0", {22'd0, addr0}, 32'd0);
    checkOutput("abort_mem_addr", mem_addr, 32'd0);
    checkOutput("abort_count", {21'd0, fetched_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 32'(done_cnt - dones0), 32'd0);
    checkOutput("abort_sb_empty", 32'(sb.size()), 32'd0);
    pushEntries(0, 2);
    applyStimulus(11'd2);
    waitDone(20);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("after_abort_count", {21'd0, fetched_count}, 32'd2);
    checkOutput("after_abort_sb_empty", 32'(sb.size()), 32'd0);

    // start re-pulsed while busy must not disturb the running replay
    $display("[TB] start while busy");
    reads0 = read_cnt;
    hs0 = hs_cnt;
    dones0 = done_cnt;
    pushEntries(0, 3);
    applyStimulus(11'd3);
    start = 1'b1;
    trace_len = 11'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    trace_len = 11'd7;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(30);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy_start_count", {21'd0, fetched_count}, 32'd3);
    checkOutput("busy_start_reads", 32'(read_cnt - reads0), 32'd3);
    checkOutput("busy_start_hs", 32'(hs_cnt - hs0), 32'd3);
    checkOutput("busy_start_done", 32'(done_cnt - dones0), 32'd1);
    checkOutput("busy_start_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_fetch.md
TRACE_FETCH -- requirements
Module: trace_fetch

Interface
REQ-001 Parameter ADDR_W, default 10, SRAM word-address width (1024-entry trace memory).
REQ-002 Parameter DATA_W, default 32, trace word width (one memory address per entry).
REQ-003 clk  input  1  single clock for all logic (wb_clk_i domain).
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 start  input  1  single-cycle pulse that begins a trace replay.
REQ-006 trace_len  input  ADDR_W+1  number of entries to replay, sampled when start is accepted.
REQ-007 csb0  output  1  SRAM chip select, active-low.
REQ-008 web0  output  1  SRAM write enable, active-low; tied high because this block only reads.
REQ-009 addr0  output  ADDR_W  SRAM word address.
REQ-010 dout0  input  DATA_W  SRAM read data, valid one clk after the csb0-low cycle.
REQ-011 mem_addr  output  DATA_W  trace entry presented to the cache model.
REQ-012 addr_valid  output  1  mem_addr is valid.
REQ-013 addr_ready  input  1  cache model accepts mem_addr.
REQ-014 busy  output  1  replay is in progress.
REQ-015 done  output  1  one-cycle pulse when the replay completes.
REQ-016 fetched_count  output  ADDR_W+1  number of entries accepted by the cache model in the current or last replay.

Function
REQ-017 The block shall use a four-state FSM: IDLE, READ, CAPT, SEND.
REQ-018 IDLE: start=1 with trace_len>0 shall latch len = min(trace_len, 2^ADDR_W), clear idx and fetched_count, and go to READ. start=1 with trace_len=0 shall pulse done the next cycle, remain IDLE, and clear fetched_count.
REQ-019 READ: for exactly one cycle, csb0=0 and addr0=idx; go to CAPT.
REQ-020 CAPT: the block shall register dout0 into mem_addr and go to SEND. csb0=1.
REQ-021 SEND: addr_valid=1 and mem_addr shall be held stable until a cycle with addr_valid & addr_ready (handshake).
REQ-022 On handshake: fetched_count+1. If idx+1 == len, go to IDLE and pulse done in the next cycle. Otherwise, set idx+1 and go to READ.
REQ-023 addr_valid shall never deassert in SEND before the handshake; addr_ready has no effect outside SEND.
REQ-024 busy=1 in READ, CAPT and SEND; busy=0 in IDLE, including the done cycle.
REQ-025 start shall be ignored while busy=1.
REQ-026 Throughput shall be one entry per 3 cycles at addr_ready=1; latency from start to first addr_valid shall be 3 cycles (READ, CAPT, SEND).
REQ-027 idx shall never exceed len-1. With len = 1024, addr0 shall reach 1023 with no wrap to 0.
REQ-028 Outside READ: csb0=1 and addr0 holds its last value. web0=1 in all cycles.
REQ-029 fetched_count shall hold its final value after done until the next accepted start.

Reset
REQ-030 When reset=0 at a clk edge, the block shall set state=IDLE, csb0=1, web0=1, addr0=0, mem_addr=0, addr_valid=0, busy=0, done=0, fetched_count=0, idx=0, len=0.
REQ-031 Reset mid-replay shall abort immediately without a done pulse; addr_valid shall drop in the cycle after the reset edge.
REQ-032 start asserted while reset=0 shall be ignored.

Verification
REQ-033 SRAM model holds 0x1000+i at word i; start with trace_len=4 and addr_ready=1 -> mem_addr shows 0x1000..0x1003 in order, addr_valid is first high 3 cycles after start, done pulses once, fetched_count=4.
REQ-034 trace_len=3 with addr_ready held low 5 cycles on entry 1 -> mem_addr=0x1001 stays stable with addr_valid=1 throughout, no extra SRAM read occurs, final fetched_count=3.
REQ-035 trace_len=0 -> csb0 is never low, done pulses 1 cycle after start, busy stays 0.
REQ-036 trace_len=1100 -> exactly 1024 handshakes, last addr0=1023, done pulses, fetched_count=1024.
REQ-037 reset=0 asserted at the 2nd SEND -> no done pulse, all outputs at reset values, and a new start with trace_len=2 replays from word 0.
REQ-038 start re-pulsed while busy -> ignored, and the original replay completes unchanged.
